// File: rtl/cnn_pkg.sv
// Shared types for the convolution front end: streamer FSM states and the
// pixel beat carried from the frame RAM to the convolution input.
package cnn_pkg;

    localparam int unsigned PIXEL_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [PIXEL_W-1:0] pixel;
        logic               sof;
        logic               eol;
    } beat_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO holding pixel beats between the RAM read pipeline and the
// consumer; the head entry is a register so it stays stable while stalled.
module pixel_skid_fifo
    import cnn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  beat_t      push_data,
    input  logic       pop,
    output beat_t      head,
    output logic       valid,
    output logic [1:0] count
);

    beat_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != 2'd0);

endmodule

// File: rtl/frame_streamer.sv
// Reads one frame from a synchronous-read pixel RAM and streams it in raster
// order with valid/ready and frame/line markers. Define FRAME_STREAMER_PAD_EN
// to emit a one-pixel zero border around the stored frame.
module frame_streamer
    import cnn_pkg::*;
#(
    parameter  int unsigned WORD_SIZE  = PIXEL_W,
    parameter  int unsigned ROW_SIZE   = 540,
    parameter  int unsigned NUM_ROWS   = 540,
    localparam int unsigned ADDR_WIDTH = $clog2(ROW_SIZE * NUM_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  memRdEn,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [WORD_SIZE-1:0]  memRdData,
    output logic [WORD_SIZE-1:0]  outputPixel,
    output logic                  outputValid,
    input  logic                  outputReady,
    output logic                  startOfFrame,
    output logic                  endOfLine
);

`ifdef FRAME_STREAMER_PAD_EN
    localparam int unsigned BORDER = 1;
`else
    localparam int unsigned BORDER = 0;
`endif
    localparam int unsigned EMIT_W = ROW_SIZE + 2 * BORDER;
    localparam int unsigned EMIT_H = NUM_ROWS + 2 * BORDER;
    localparam int unsigned COL_W  = $clog2(EMIT_W + 1);
    localparam int unsigned ROW_W  = $clog2(EMIT_H + 1);

    state_t                state;
    state_t                state_nxt;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd_valid;
    logic                  rd_sof;
    logic                  rd_eol;
    logic                  rd_pad;
    logic                  fetch_c;
    logic                  pad_c;
    logic                  col_last_c;
    logic                  last_fetch_c;
    logic                  pop_c;
    logic                  drained_c;
    logic                  fifo_valid;
    logic [1:0]            occ;
    beat_t                 push_beat;
    beat_t                 head;

    // Fetch only when the FIFO is guaranteed room for the returning data.
    assign pop_c        = fifo_valid && outputReady;
    assign col_last_c   = (col == COL_W'(EMIT_W - 1));
    assign last_fetch_c = col_last_c && (row == ROW_W'(EMIT_H - 1));
    assign fetch_c      = (state == STREAM) &&
                          ((3'(occ) + 3'(rd_valid) - 3'(pop_c)) <= 3'd1);
    assign drained_c    = !fifo_valid && !rd_valid;

`ifdef FRAME_STREAMER_PAD_EN
    assign pad_c = (row == '0) || (col == '0) || col_last_c ||
                   (row == ROW_W'(EMIT_H - 1));
`else
    assign pad_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (fetch_c && last_fetch_c) state_nxt = DRAIN;
            DRAIN:   if (drained_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DRAIN) && drained_c;
        memRdEn = fetch_c && !pad_c;
    end

    // Raster counters plus the one-deep record of the fetch whose data returns next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            addr     <= '0;
            rd_valid <= 1'b0;
            rd_sof   <= 1'b0;
            rd_eol   <= 1'b0;
            rd_pad   <= 1'b0;
        end else begin
            rd_valid <= fetch_c;
            rd_sof   <= fetch_c && (row == '0) && (col == '0);
            rd_eol   <= fetch_c && col_last_c;
            rd_pad   <= pad_c;
            if (state != STREAM) begin
                col  <= '0;
                row  <= '0;
                addr <= '0;
            end else if (fetch_c) begin
                if (col_last_c) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
                if (!pad_c) begin
                    addr <= addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        push_beat.pixel = rd_pad ? '0 : PIXEL_W'(memRdData);
        push_beat.sof   = rd_sof;
        push_beat.eol   = rd_eol;
    end

    pixel_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_valid),
        .push_data (push_beat),
        .pop       (pop_c),
        .head      (head),
        .valid     (fifo_valid),
        .count     (occ)
    );

    assign memAddr      = addr;
    assign outputValid  = fifo_valid;
    assign outputPixel  = WORD_SIZE'(head.pixel);
    assign startOfFrame = fifo_valid && head.sof;
    assign endOfLine    = fifo_valid && head.eol;

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: stimulus pushes expected beats into a
// queue and a negedge monitor compares every presented output against it.
module tb_frame_streamer;

`ifdef FRAME_STREAMER_PAD_EN
    localparam int R   = 2;
    localparam int N   = 2;
    localparam int B   = 1;
    localparam int OFF = 10;
`else
    localparam int R   = 4;
    localparam int N   = 3;
    localparam int B   = 0;
    localparam int OFF = 0;
`endif
    localparam int WS   = 8;
    localparam int AW   = $clog2(R * N);
    localparam int EW   = R + 2 * B;
    localparam int EH   = N + 2 * B;
    localparam int EMIT = EW * EH;
    localparam int BW   = WS + 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          memRdEn;
    logic [AW-1:0] memAddr;
    logic [WS-1:0] memRdData;
    logic [WS-1:0] outputPixel;
    logic          outputValid;
    logic          outputReady;
    logic          startOfFrame;
    logic          endOfLine;

    frame_streamer #(
        .WORD_SIZE (WS),
        .ROW_SIZE  (R),
        .NUM_ROWS  (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .memRdEn      (memRdEn),
        .memAddr      (memAddr),
        .memRdData    (memRdData),
        .outputPixel  (outputPixel),
        .outputValid  (outputValid),
        .outputReady  (outputReady),
        .startOfFrame (startOfFrame),
        .endOfLine    (endOfLine)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_edge;
    int xfer_count, rd_count, done_count;
    int first_xfer_cyc, last_xfer_cyc, done_cyc;
    logic ready_mode  = 1'b0;
    logic ready_level = 1'b1;
    logic stalled     = 1'b0;
    logic [BW-1:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    // RAM model: synchronous read, contents a + OFF
    always @(posedge clk) begin
        if (memRdEn) memRdData <= WS'(int'(memAddr) + OFF);
    end

    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph  = 0;
        outputReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                outputReady = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                outputReady = ready_level;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [BW-1:0] exp_beat(input int idx);
        int r;
        int c;
        logic [WS-1:0] p;
        r = idx / EW;
        c = idx % EW;
        if (B == 1 && (r == 0 || r == EH - 1 || c == 0 || c == EW - 1)) p = '0;
        else p = WS'((r - B) * R + (c - B) + OFF);
        return {p, (idx == 0), (c == EW - 1)};
    endfunction

    // Monitor: every valid cycle must show the queue head; pop on transfer.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) chk("hold_valid", outputValid, 1);
            if (memRdEn) rd_count++;
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (outputValid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_pixel: got %0d with no pixel expected (cyc %0d)", outputPixel, cyc);
                end else begin
                    chk("beat", {outputPixel, startOfFrame, endOfLine}, exp_q[0]);
                    if (outputReady) begin
                        void'(exp_q.pop_front());
                        if (xfer_count == 0) first_xfer_cyc = cyc;
                        last_xfer_cyc = cyc;
                        xfer_count++;
                    end
                end
            end
            stalled = outputValid && !outputReady;
        end
    end

    task automatic clear_stats();
        xfer_count     = 0;
        rd_count       = 0;
        done_count     = 0;
        first_xfer_cyc = -1;
        last_xfer_cyc  = -1;
        done_cyc       = -1;
        exp_q.delete();
    endtask

    task automatic push_frame(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_beat(i));
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        start_edge = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_high", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_count;
        n  = 0;
        while (done_count == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", (done_count != d0), 1);
    endtask

    task automatic check_stats(input logic timing);
        chk("xfer_count", xfer_count, EMIT);
        chk("rd_count", rd_count, R * N);
        chk("done_count", done_count, 1);
        chk("queue_empty", exp_q.size(), 0);
        if (timing) begin
            chk("first_latency", first_xfer_cyc - start_edge, 2);
            chk("last_cycle", last_xfer_cyc - start_edge, EMIT + 1);
            chk("done_cycle", done_cyc - last_xfer_cyc, 1);
        end
        @(negedge clk);
        chk("busy_low", busy, 0);
        chk("done_low", done, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rden"}, memRdEn, 0);
        chk({tag, "_addr"}, memAddr, 0);
        chk({tag, "_pixel"}, outputPixel, 0);
        chk({tag, "_valid"}, outputValid, 0);
        chk({tag, "_sof"}, startOfFrame, 0);
        chk({tag, "_eol"}, endOfLine, 0);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_beats_start", busy, 0);

        // Full frame with ready held high
        clear_stats();
        push_frame(EMIT);
        pulse_start();
        wait_done(EMIT * 8 + 50);
        check_stats(1'b1);

        // Ready toggling 1,0,0,1
        ready_mode = 1'b1;
        clear_stats();
        push_frame(EMIT);
        pulse_start();
        wait_done(EMIT * 8 + 50);
        check_stats(1'b0);
        ready_mode = 1'b0;
        repeat (2) @(posedge clk);

        // Start re-asserted mid-frame is ignored
        clear_stats();
        push_frame(EMIT);
        pulse_start();
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(EMIT * 8 + 50);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("no_second_frame", outputValid, 0);
        check_stats(1'b1);
        clear_stats();
        push_frame(EMIT);
        pulse_start();
        wait_done(EMIT * 8 + 50);
        check_stats(1'b1);

        // Reset after the sixth transfer
        clear_stats();
        push_frame(6);
        pulse_start();
        n = 0;
        while (xfer_count < 6 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("six_transfers", xfer_count, 6);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        chk("midrst_no_done", done_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_stats();
        push_frame(EMIT);
        pulse_start();
        wait_done(EMIT * 8 + 50);
        check_stats(1'b1);

        // Ready low for 10 cycles from start
        ready_level = 1'b0;
        repeat (3) @(posedge clk);
        clear_stats();
        push_frame(EMIT);
        pulse_start();
        repeat (10) @(negedge clk);
        chk("stall_reads_le2", (rd_count <= 2), 1);
        chk("stall_no_xfer", xfer_count, 0);
        chk("stall_valid", outputValid, 1);
        chk("stall_pixel", outputPixel, exp_beat(0) >> 2);
        ready_level = 1'b1;
        wait_done(EMIT * 8 + 50);
        check_stats(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
